// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC parallel-bus burst sequencer.
// Phase boundaries describe one 10-cycle register access on the multiplexed bus.
package rtc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int N_REGS_DEFAULT    = 18;
  localparam int PHASE_LEN_DEFAULT = 10;

  localparam logic [3:0] ADDR_STB_LO = 4'd1;
  localparam logic [3:0] ADDR_STB_HI = 4'd2;
  localparam logic [3:0] ADDR_END    = 4'd3;
  localparam logic [3:0] GAP         = 4'd4;
  localparam logic [3:0] DATA_START  = 4'd5;
  localparam logic [3:0] STROBE_LO   = 4'd6;
  localparam logic [3:0] STROBE_HI   = 4'd7;
  localparam logic [3:0] CAPTURE     = 4'd8;

  // Bus address of each RTC register, in burst order.
  localparam logic [7:0] RTC_ADDR [18] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
    8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B,
    8'h0C, 8'h0D, 8'h20, 8'h21, 8'h22, 8'h23
  };

  function automatic logic inRange(input logic [3:0] value,
                                   input logic [3:0] lo,
                                   input logic [3:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/rtc_phase_decoder.sv
// Combinational decode of access phase and burst direction into strobe levels.
// The parent feeds it the next-cycle phase so the registered strobes line up with o_phase.
module rtc_phase_decoder
  import rtc_bus_pkg::*;
(
  input  logic       i_active,
  input  logic [3:0] i_phase,
  input  logic       i_read,
  output logic       o_csN,
  output logic       o_adN,
  output logic       o_wrN,
  output logic       o_rdN,
  output logic       o_oe,
  output logic       o_selData
);

  always_comb begin
    o_csN     = 1'b1;
    o_adN     = 1'b1;
    o_wrN     = 1'b1;
    o_rdN     = 1'b1;
    o_oe      = 1'b0;
    o_selData = 1'b0;
    if (i_active) begin
      if (i_phase <= ADDR_END) begin
        o_csN = 1'b0;
        o_adN = 1'b0;
        o_oe  = 1'b1;
        o_wrN = !inRange(i_phase, ADDR_STB_LO, ADDR_STB_HI);
      end else if (i_phase == GAP) begin
        o_oe = 1'b0;
      end else if (inRange(i_phase, DATA_START, CAPTURE)) begin
        o_csN = 1'b0;
        if (i_read) begin
          o_rdN = !inRange(i_phase, STROBE_LO, STROBE_HI);
        end else begin
          o_oe      = 1'b1;
          o_selData = 1'b1;
          o_wrN     = !inRange(i_phase, STROBE_LO, STROBE_HI);
        end
      end
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Runs one 18-register read or write burst over the multiplexed RTC bus,
// driving registered strobes and capturing read bytes at the end of the read strobe.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int N_REGS    = N_REGS_DEFAULT,
  parameter int PHASE_LEN = PHASE_LEN_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_w_r,
  input  logic [7:0] i_wr_data,
  input  logic [7:0] i_bus_din,
  output logic       o_busy,
  output logic       o_done,
  output logic [4:0] o_reg_idx,
  output logic [3:0] o_phase,
  output logic       o_cs_n,
  output logic       o_ad_n,
  output logic       o_wr_n,
  output logic       o_rd_n,
  output logic [7:0] o_bus_dout,
  output logic       o_bus_oe,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic [4:0] o_rd_idx
);

  localparam logic [4:0] LAST_IDX   = 5'(N_REGS - 1);
  localparam logic [3:0] LAST_PHASE = 4'(PHASE_LEN - 1);

  state_t     r_state, w_nextState;
  logic [4:0] r_regIdx, w_nextIdx;
  logic [3:0] r_phase, w_nextPhase;
  logic       r_read, w_nextRead;

  logic       r_csN, r_adN, r_wrN, r_rdN, r_busOe;
  logic [7:0] r_busDout, r_rdData;
  logic       r_rdValid;
  logic [4:0] r_rdIdx;

  logic       w_csN, w_adN, w_wrN, w_rdN, w_oe, w_selData;
  logic [7:0] w_nextDout;
  logic       w_capture;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_regIdx <= '0;
      r_phase  <= '0;
      r_read   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_regIdx <= w_nextIdx;
      r_phase  <= w_nextPhase;
      r_read   <= w_nextRead;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_regIdx;
    w_nextPhase = r_phase;
    w_nextRead  = r_read;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_nextState = ST_ACCESS;
          w_nextIdx   = '0;
          w_nextPhase = '0;
          w_nextRead  = i_w_r;
        end
      end
      ST_ACCESS: begin
        if (r_phase == LAST_PHASE) begin
          if (r_regIdx == LAST_IDX) begin
            w_nextState = ST_DONE;
          end else begin
            w_nextIdx   = r_regIdx + 5'd1;
            w_nextPhase = '0;
          end
        end else begin
          w_nextPhase = r_phase + 4'd1;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  rtc_phase_decoder u_decoder (
    .i_active  (w_nextState == ST_ACCESS),
    .i_phase   (w_nextPhase),
    .i_read    (w_nextRead),
    .o_csN     (w_csN),
    .o_adN     (w_adN),
    .o_wrN     (w_wrN),
    .o_rdN     (w_rdN),
    .o_oe      (w_oe),
    .o_selData (w_selData)
  );

  // Undriven bus cycles park the output byte at zero.
  assign w_nextDout = !w_oe     ? 8'h00 :
                      w_selData ? i_wr_data : RTC_ADDR[w_nextIdx];

  assign w_capture = (r_state == ST_ACCESS) && r_read && (r_phase == STROBE_HI);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_csN     <= 1'b1;
      r_adN     <= 1'b1;
      r_wrN     <= 1'b1;
      r_rdN     <= 1'b1;
      r_busOe   <= 1'b0;
      r_busDout <= 8'h00;
      r_rdValid <= 1'b0;
      r_rdData  <= 8'h00;
      r_rdIdx   <= '0;
    end else begin
      r_csN     <= w_csN;
      r_adN     <= w_adN;
      r_wrN     <= w_wrN;
      r_rdN     <= w_rdN;
      r_busOe   <= w_oe;
      r_busDout <= w_nextDout;
      r_rdValid <= w_capture;
      if (w_capture) begin
        r_rdData <= i_bus_din;
        r_rdIdx  <= r_regIdx;
      end
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_reg_idx  = r_regIdx;
  assign o_phase    = r_phase;
  assign o_cs_n     = r_csN;
  assign o_ad_n     = r_adN;
  assign o_wr_n     = r_wrN;
  assign o_rd_n     = r_rdN;
  assign o_bus_dout = r_busDout;
  assign o_bus_oe   = r_busOe;
  assign o_rd_data  = r_rdData;
  assign o_rd_valid = r_rdValid;
  assign o_rd_idx   = r_rdIdx;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: reset, write and read bursts, start while busy,
// start in the DONE cycle, and a reset in the middle of a burst.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, wR;
  logic [7:0] wrData, busDin;
  logic       busy, done, csN, adN, wrN, rdN, busOe, rdValid;
  logic [4:0] regIdx, rdIdx;
  logic [3:0] phase;
  logic [7:0] busDout, rdData;

  int checks = 0;
  int passes = 0;

  localparam logic [7:0] ADDR_TAB [18] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
    8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B,
    8'h0C, 8'h0D, 8'h20, 8'h21, 8'h22, 8'h23
  };

  // Expected {cs_n, ad_n, wr_n, rd_n, bus_oe} for each phase of one access.
  localparam logic [4:0] WR_STB [10] = '{
    5'b00111, 5'b00011, 5'b00011, 5'b00111, 5'b11110,
    5'b01111, 5'b01011, 5'b01011, 5'b01111, 5'b11110
  };
  localparam logic [4:0] RD_STB [10] = '{
    5'b00111, 5'b00011, 5'b00011, 5'b00111, 5'b11110,
    5'b01110, 5'b01100, 5'b01100, 5'b01110, 5'b11110
  };
  localparam logic [4:0] IDLE_STB = 5'b11110;

  rtc_bus_sequencer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_w_r      (wR),
    .i_wr_data  (wrData),
    .i_bus_din  (busDin),
    .o_busy     (busy),
    .o_done     (done),
    .o_reg_idx  (regIdx),
    .o_phase    (phase),
    .o_cs_n     (csN),
    .o_ad_n     (adN),
    .o_wr_n     (wrN),
    .o_rd_n     (rdN),
    .o_bus_dout (busDout),
    .o_bus_oe   (busOe),
    .o_rd_data  (rdData),
    .o_rd_valid (rdValid),
    .o_rd_idx   (rdIdx)
  );

  always #5 clk = ~clk;

  // The RTC answers a read with 0x30 plus the register index on the bus.
  assign busDin = 8'h30 + {3'b000, regIdx};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string where);
    checkOutput({where, " strobes"}, {csN, adN, wrN, rdN, busOe}, IDLE_STB);
    checkOutput({where, " busy/done/rdValid"}, {busy, done, rdValid}, 3'b000);
    checkOutput({where, " idx/phase"}, {regIdx, phase}, 9'd0);
    checkOutput({where, " rdIdx/rdData"}, {rdIdx, rdData}, 13'd0);
    checkOutput({where, " busDout"}, busDout, 8'h00);
  endtask

  // Starts a burst from IDLE and checks every cycle through DONE and back to IDLE.
  // The DONE cycle always carries a start pulse that must be ignored.
  task automatic applyStimulus(input logic isRead, input int pokeCycle);
    int idx, ph;
    logic expValid;
    wR = isRead;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 180; c++) begin
      wR = ~isRead;
      start = (c == pokeCycle);
      idx = (c - 1) / 10;
      ph  = (c - 1) % 10;
      checkOutput("idx/phase", {regIdx, phase}, {idx[4:0], ph[3:0]});
      checkOutput("strobes", {csN, adN, wrN, rdN, busOe}, isRead ? RD_STB[ph] : WR_STB[ph]);
      checkOutput("busy/done", {busy, done}, 2'b10);
      if (ph <= 3) checkOutput("address", busDout, ADDR_TAB[idx]);
      else if (!isRead && ph >= 5 && ph <= 8) checkOutput("write data", busDout, 8'hA5);
      expValid = isRead && (ph == 8);
      checkOutput("rdValid", rdValid, expValid);
      if (expValid) begin
        checkOutput("rdData", rdData, 8'h30 + idx[7:0]);
        checkOutput("rdIdx", rdIdx, idx[4:0]);
      end
      tick();
    end
    checkOutput("done cycle busy/done", {busy, done, rdValid}, 3'b110);
    checkOutput("done cycle strobes", {csN, adN, wrN, rdN, busOe}, IDLE_STB);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("idle after done", {busy, done}, 2'b00);
    checkOutput("idle strobes", {csN, adN, wrN, rdN, busOe}, IDLE_STB);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    wR = 1'b0;
    wrData = 8'hA5;
    repeat (3) tick();
    checkResetState("reset");
    rst = 1'b0;
    start = 1'b0;
    tick();
    checkResetState("post-reset");

    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 51);

    wR = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (96) tick();
    checkOutput("pre-reset position", {regIdx, phase}, {5'd9, 4'd6});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("mid-burst reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("quiet after reset", {busy, done, rdValid}, 3'b000);
    end

    applyStimulus(1'b0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Sequences one complete read or write burst of 18 RTC registers (index 0..17) over the multiplexed address/data parallel bus. Generates the register index and per-access phase count, and drives the chip strobes. Captures read data and hands write data out from the register file. Sits between the top-level control FSM (start/done handshake) and the RTC bus pins, and drives the read/write counters' stepping signals.

## Interface
- N_REGS, 18, registers per burst; index range 0..N_REGS-1
- PHASE_LEN, 10, clock cycles per register access; phase range 0..PHASE_LEN-1
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  burst request; accepted only in IDLE
- W_R  in  1  1 = read burst, 0 = write burst; latched when start is accepted
- wr_data  in  8  write byte for the current reg_idx (from the register file)
- bus_din  in  8  RTC bus input
- busy  out  1  high from the cycle after start is accepted through the DONE state
- done  out  1  one-cycle pulse when the burst ends
- reg_idx  out  5  current register index
- phase  out  4  current phase within the access
- cs_n, ad_n, wr_n, rd_n  out  1 each  RTC strobes, active-low
- bus_dout  out  8  address or write data
- bus_oe  out  1  bus output enable
- rd_data  out  8  captured read byte
- rd_valid  out  1  one-cycle pulse with rd_data
- rd_idx  out  5  index of rd_data

## Operation
- **FSM states:** IDLE → ACCESS → DONE → IDLE.
- **IDLE:**
  - start=1 latches W_R, clears reg_idx and phase, and moves to ACCESS.
  - start is ignored in ACCESS and DONE.
- **ACCESS, phase counting:**
  - phase increments every cycle.
  - At phase=PHASE_LEN-1:
    - reg_idx=N_REGS-1 → go to DONE;
    - otherwise reg_idx+1 and phase=0.
  - reg_idx never exceeds 17 and never wraps inside a burst.
- **ACCESS, address sub-cycle (phases 0-3):**
  - cs_n=0, ad_n=0, bus_oe=1.
  - bus_dout=RTC_ADDR[reg_idx].
  - wr_n=0 in phases 1-2.
- **ACCESS, gap:** phase 4: all strobes high, bus_oe=0.
- **ACCESS, data sub-cycle (phases 5-8):**
  - cs_n=0, ad_n=1.
  - Write burst: bus_oe=1, bus_dout=wr_data, wr_n=0 in phases 6-7.
  - Read burst: bus_oe=0, rd_n=0 in phases 6-7.
- **ACCESS, phase 9:** all strobes high, bus_oe=0.
- **Read capture:**
  - bus_din is registered on the clk edge that ends phase 7.
  - rd_valid=1 for exactly the phase-8 cycle, with rd_data and rd_idx=reg_idx.
  - rd_valid never fires on write bursts.
- **DONE:** done=1 and busy=1 for one cycle, strobes high, then IDLE.
- **Registered outputs:** all strobes are registered. They are never low in IDLE or DONE, and never low during phases 4 or 9.

## Timing
- **Reset values:**
  - State IDLE; busy=0, done=0, rd_valid=0, bus_oe=0.
  - cs_n=ad_n=wr_n=rd_n=1.
  - reg_idx=0, phase=0, rd_idx=0, rd_data=0, bus_dout=0.
- **Latency:**
  - start sampled high in cycle T → ACCESS phase 0 in T+1.
  - Last phase 9 (idx 17) in T+180; done in T+181; IDLE in T+182.
- **Start during done:** start in the DONE cycle is ignored; start in T+182 is accepted.
- **Reset mid-burst:** rst has priority over everything. On the next edge all outputs take their reset values; no done and no rd_valid is produced.
- **Simultaneous rst and start:** rst wins; start is not latched.
- **W_R changes mid-burst:** no effect; the latched copy is used.

## Structure
- **Package rtc_bus_pkg holds:**
  - the state enum;
  - the N_REGS and PHASE_LEN defaults;
  - phase boundary constants (ADDR_END=3, GAP=4, DATA_START=5, STROBE_LO=6, STROBE_HI=7, CAPTURE=8);
  - RTC_ADDR, an 18-entry byte address table.
- **Sub-module rtc_phase_decoder:** combinational phase/W_R → next strobe values, registered in the parent.

## Test plan
- **Reset:** hold rst for 3 cycles with start=1 → all reset values; no ACCESS entry.
- **Write burst:** W_R=0, start pulse, wr_data=8'hA5.
  - Idx 0: ad_n=0 in phases 0-3, bus_dout=RTC_ADDR[0], wr_n=0 in phases 1-2 and 6-7, bus_dout=8'hA5 in phases 5-8.
  - done at T+181; rd_valid never high.
- **Read burst:** W_R=1, bus model returns 8'h30+idx.
  - 18 rd_valid pulses, each at phase 8, with rd_idx 0..17 and rd_data 8'h30..8'h41.
  - wr_n stays high during data phases.
- **Start while busy:** start pulse at idx 5 → no restart; reg_idx continues to 6; a single done.
- **Mid-burst reset:** rst at idx 9 phase 6 → next cycle all strobes high, IDLE, reg_idx=0; a new start then runs a full 181-cycle burst.
- **Boundary:** start in the DONE cycle is ignored; start the next cycle is accepted; reg_idx goes 17→DONE, never 18.
